// File: rtl/tlul_pkg.sv
// TL-UL channel structs and opcodes for the A (host to device) and D (device to host) channels.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                          a_valid;
    tl_a_op_e                      a_opcode;
    logic [2:0]                    a_param;
    logic [top_pkg::TL_SZW-1:0]    a_size;
    logic [top_pkg::TL_AIW-1:0]    a_source;
    logic [top_pkg::TL_AW-1:0]     a_address;
    logic [top_pkg::TL_DBW-1:0]    a_mask;
    logic [top_pkg::TL_DW-1:0]     a_data;
    logic                          d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                          d_valid;
    tl_d_op_e                      d_opcode;
    logic [2:0]                    d_param;
    logic [top_pkg::TL_SZW-1:0]    d_size;
    logic [top_pkg::TL_AIW-1:0]    d_source;
    logic [top_pkg::TL_DIW-1:0]    d_sink;
    logic [top_pkg::TL_DW-1:0]     d_data;
    logic                          d_error;
    logic                          a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/top_pkg.sv
// Bus-wide width constants shared by the TL-UL type definitions.
package top_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW >> 3;

endpackage

// File: rtl/tlul_reg_host.sv
// TL-UL host adapter: one register request at a time from a req/gnt/rvalid port onto TL-UL,
// with local alignment/mask checks, response checking and a response timeout.
module tlul_reg_host
  import tlul_pkg::*;
#(
  parameter int unsigned AW            = 32,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] be_i,
  output logic            gnt_o,
  output logic            rvalid_o,
  output logic [DW-1:0]   rdata_o,
  output logic            err_o,
  output logic            busy_o,
  output tl_h2d_t         tl_o,
  input  tl_d2h_t         tl_i
);
  localparam int AIW = top_pkg::TL_AIW;
  localparam int TAW = top_pkg::TL_AW;
  localparam int unsigned CW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CW-1:0] CntMax = CW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [TAW-1:0]    addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic [AIW-1:0]    src_q, src_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              d_match, d_bad;

  logic unused_d;
  assign unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

  // src_q already advanced at the A handshake, so the outstanding source is one behind.
  assign d_match = tl_i.d_valid && (tl_i.d_source == (src_q - AIW'(1)));
  assign d_bad   = tl_i.d_error ||
                   (we_q ? (tl_i.d_opcode != AccessAck) : (tl_i.d_opcode != AccessAckData));

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          if ((addr_i[1:0] != 2'b00) || (we_i && (be_i == '0))) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = REQ;
            we_d    = we_i;
            addr_d  = TAW'(addr_i);
            wdata_d = we_i ? wdata_i : '0;
            be_d    = we_i ? be_i : '1;
          end
        end
      end
      REQ: begin
        if (tl_i.a_ready) begin
          state_d = RSP;
          src_d   = src_q + AIW'(1);
          cnt_d   = '0;
        end
      end
      RSP: begin
        // A matching beat in the expiry cycle still completes normally.
        if (d_match) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = d_bad;
          rdata_d  = (!d_bad && !we_q) ? tl_i.d_data : '0;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntMax)) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      src_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    tl_o         = '0;
    tl_o.d_ready = 1'b1;
    if (state_q == REQ) begin
      tl_o.a_valid   = 1'b1;
      tl_o.a_opcode  = !we_q ? Get : ((be_q == '1) ? PutFullData : PutPartialData);
      tl_o.a_size    = top_pkg::TL_SZW'(2);
      tl_o.a_source  = src_q;
      tl_o.a_address = addr_q;
      tl_o.a_mask    = be_q;
      tl_o.a_data    = wdata_q;
    end
  end

  assign gnt_o    = (state_q == IDLE) && req_i;
  assign busy_o   = (state_q != IDLE);
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_tlul_reg_host.sv
// Directed bench for tlul_reg_host: a hand-driven TL-UL device checks A fields and completions.
module tb_tlul_reg_host;
  import tlul_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o, busy_o;
  logic [31:0] rdata_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_src  = 8'd0;

  tlul_reg_host #(.AW(32), .DW(32), .TimeoutCycles(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .busy_o(busy_o), .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
  endtask

  task automatic clear_req();
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic drive_d(input logic [7:0] src, input tl_d_op_e op, input logic derr,
                         input logic [31:0] data);
    tl_i.d_valid = 1'b1; tl_i.d_source = src; tl_i.d_opcode = op;
    tl_i.d_error = derr; tl_i.d_data = data;
  endtask

  task automatic bus_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [2:0] exp_op, input logic [3:0] exp_mask,
                         input int stall, input int bad_src,
                         input tl_d_op_e d_op, input logic d_err, input logic [31:0] d_data,
                         input logic exp_err, input logic [31:0] exp_rdata);
    logic [7:0] src;
    src = exp_src;
    drive_req(we, addr, wdata, be);
    tl_i.a_ready = (stall == 0);
    #1;
    chk({tag, ".gnt"}, 64'(gnt_o), 64'd1);
    tick();
    clear_req();
    chk({tag, ".a_valid"}, 64'(tl_o.a_valid), 64'd1);
    chk({tag, ".a_opcode"}, 64'(tl_o.a_opcode), 64'(exp_op));
    chk({tag, ".a_mask"}, 64'(tl_o.a_mask), 64'(exp_mask));
    chk({tag, ".a_address"}, 64'(tl_o.a_address), 64'(addr));
    chk({tag, ".a_data"}, 64'(tl_o.a_data), we ? 64'(wdata) : 64'd0);
    chk({tag, ".a_source"}, 64'(tl_o.a_source), 64'(src));
    chk({tag, ".a_size"}, 64'(tl_o.a_size), 64'd2);
    chk({tag, ".a_param"}, 64'(tl_o.a_param), 64'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, ".stall_valid"}, 64'(tl_o.a_valid), 64'd1);
      chk({tag, ".stall_addr"}, 64'(tl_o.a_address), 64'(addr));
      chk({tag, ".stall_op"}, 64'(tl_o.a_opcode), 64'(exp_op));
    end
    tl_i.a_ready = 1'b1;
    tick();
    chk({tag, ".a_done"}, 64'(tl_o.a_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy_o), 64'd1);
    chk({tag, ".d_ready"}, 64'(tl_o.d_ready), 64'd1);
    for (int i = 0; i < bad_src; i++) begin
      drive_d(src + 8'd3, d_op, 1'b0, 32'hBAD0BAD0);
      tick();
      chk({tag, ".badsrc_rvalid"}, 64'(rvalid_o), 64'd0);
      chk({tag, ".badsrc_busy"}, 64'(busy_o), 64'd1);
    end
    drive_d(src, d_op, d_err, d_data);
    tick();
    tl_i.d_valid = 1'b0; tl_i.d_error = 1'b0;
    chk({tag, ".rvalid"}, 64'(rvalid_o), 64'd1);
    chk({tag, ".err"}, 64'(err_o), 64'(exp_err));
    chk({tag, ".rdata"}, 64'(rdata_o), 64'(exp_rdata));
    chk({tag, ".idle"}, 64'(busy_o), 64'd0);
    tick();
    chk({tag, ".rvalid_pulse"}, 64'(rvalid_o), 64'd0);
    exp_src = src + 8'd1;
    $display("txn %s: we=%0b addr=0x%0h src=%0d err=%0b rdata=0x%0h",
             tag, we, addr, src, err_o, rdata_o);
  endtask

  task automatic loc_err(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be);
    drive_req(we, addr, 32'h55AA55AA, be);
    #1;
    chk({tag, ".gnt"}, 64'(gnt_o), 64'd1);
    tick();
    clear_req();
    chk({tag, ".rvalid"}, 64'(rvalid_o), 64'd1);
    chk({tag, ".err"}, 64'(err_o), 64'd1);
    chk({tag, ".rdata"}, 64'(rdata_o), 64'd0);
    chk({tag, ".a_valid"}, 64'(tl_o.a_valid), 64'd0);
    chk({tag, ".busy"}, 64'(busy_o), 64'd0);
    tick();
    chk({tag, ".rvalid_pulse"}, 64'(rvalid_o), 64'd0);
    chk({tag, ".no_access"}, 64'(tl_o.a_valid), 64'd0);
    $display("txn %s: local error we=%0b addr=0x%0h be=0x%0h", tag, we, addr, be);
  endtask

  // Issues a read and returns in the first RSP cycle (timeout counter at zero).
  task automatic start_read(input string tag, input logic [31:0] addr);
    drive_req(1'b0, addr, 32'd0, 4'h0);
    tl_i.a_ready = 1'b1;
    #1;
    chk({tag, ".gnt"}, 64'(gnt_o), 64'd1);
    tick();
    clear_req();
    chk({tag, ".a_source"}, 64'(tl_o.a_source), 64'(exp_src));
    tick();
    chk({tag, ".busy"}, 64'(busy_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] old_src;
    int         n;
    logic       seen_err;
    logic [31:0] seen_rdata;

    tl_i = '0;
    tl_i.a_ready = 1'b1;
    clear_req();
    rst_ni = 1'b0;
    repeat (3) tick();
    chk("reset.rvalid", 64'(rvalid_o), 64'd0);
    chk("reset.err", 64'(err_o), 64'd0);
    chk("reset.rdata", 64'(rdata_o), 64'd0);
    chk("reset.busy", 64'(busy_o), 64'd0);
    chk("reset.gnt", 64'(gnt_o), 64'd0);
    chk("reset.a_valid", 64'(tl_o.a_valid), 64'd0);
    rst_ni = 1'b1;
    tick();

    bus_txn("rd10", 1'b0, 32'h10, 32'h0, 4'h0, 3'd4, 4'hF, 0, 0,
            AccessAckData, 1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
    bus_txn("wr_full", 1'b1, 32'h04, 32'h1234, 4'hF, 3'd0, 4'hF, 0, 0,
            AccessAck, 1'b0, 32'h0, 1'b0, 32'h0);
    bus_txn("wr_part", 1'b1, 32'h04, 32'h1234, 4'h3, 3'd1, 4'h3, 0, 0,
            AccessAck, 1'b0, 32'h0, 1'b0, 32'h0);
    loc_err("misalign", 1'b0, 32'h06, 4'hF);
    loc_err("wr_be0", 1'b1, 32'h08, 4'h0);
    bus_txn("rd_stall", 1'b0, 32'h30, 32'h0, 4'h0, 3'd4, 4'hF, 5, 0,
            AccessAckData, 1'b0, 32'h0BADCAFE, 1'b0, 32'h0BADCAFE);

    // Timeout: no D beat, completion with error 8 cycles after the A handshake.
    old_src = exp_src;
    start_read("tmo", 32'h20);
    n = 0; seen_err = 1'b0; seen_rdata = 32'hFFFFFFFF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (rvalid_o) begin
        n = i; seen_err = err_o; seen_rdata = rdata_o;
        break;
      end
    end
    chk("tmo.cycles", 64'(n), 64'd8);
    chk("tmo.err", 64'(seen_err), 64'd1);
    chk("tmo.rdata", 64'(seen_rdata), 64'd0);
    exp_src = old_src + 8'd1;
    $display("txn tmo: timeout after %0d cycles", n);
    drive_d(old_src, AccessAckData, 1'b0, 32'h55555555);
    tick();
    tl_i.d_valid = 1'b0;
    chk("stale.rvalid", 64'(rvalid_o), 64'd0);
    chk("stale.busy", 64'(busy_o), 64'd0);
    tick();
    chk("stale.rvalid2", 64'(rvalid_o), 64'd0);
    $display("txn stale: late beat src=%0d dropped", old_src);
    bus_txn("rd_after", 1'b0, 32'h24, 32'h0, 4'h0, 3'd4, 4'hF, 0, 0,
            AccessAckData, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);

    bus_txn("d_error", 1'b0, 32'h10, 32'h0, 4'h0, 3'd4, 4'hF, 0, 0,
            AccessAckData, 1'b1, 32'h12345678, 1'b1, 32'h0);
    bus_txn("rd_ack", 1'b0, 32'h10, 32'h0, 4'h0, 3'd4, 4'hF, 0, 0,
            AccessAck, 1'b0, 32'h12345678, 1'b1, 32'h0);
    bus_txn("wr_ackd", 1'b1, 32'h0C, 32'hA5A5, 4'hF, 3'd0, 4'hF, 0, 0,
            AccessAckData, 1'b0, 32'h0, 1'b1, 32'h0);
    bus_txn("bad_src", 1'b0, 32'h14, 32'h0, 4'h0, 3'd4, 4'hF, 0, 2,
            AccessAckData, 1'b0, 32'h600DF00D, 1'b0, 32'h600DF00D);

    // Matching beat in the same cycle the timeout would fire: normal completion.
    old_src = exp_src;
    start_read("edge", 32'h28);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("edge.wait_rvalid", 64'(rvalid_o), 64'd0);
    end
    drive_d(old_src, AccessAckData, 1'b0, 32'h87654321);
    tick();
    tl_i.d_valid = 1'b0;
    chk("edge.rvalid", 64'(rvalid_o), 64'd1);
    chk("edge.err", 64'(err_o), 64'd0);
    chk("edge.rdata", 64'(rdata_o), 64'h87654321);
    exp_src = old_src + 8'd1;
    $display("txn edge: beat on final timeout cycle completed rdata=0x%0h", rdata_o);

    // Reset while the A request is stalled.
    drive_req(1'b0, 32'h40, 32'h0, 4'h0);
    tl_i.a_ready = 1'b0;
    tick();
    clear_req();
    chk("rst_mid.a_valid_before", 64'(tl_o.a_valid), 64'd1);
    rst_ni = 1'b0;
    tick();
    chk("rst_mid.a_valid", 64'(tl_o.a_valid), 64'd0);
    chk("rst_mid.busy", 64'(busy_o), 64'd0);
    rst_ni = 1'b1;
    tl_i.a_ready = 1'b1;
    exp_src = 8'd0;
    tick();
    $display("txn rst_mid: reset during stalled request");
    bus_txn("rd_post_rst", 1'b0, 32'h44, 32'h0, 4'h0, 3'd4, 4'hF, 0, 0,
            AccessAckData, 1'b0, 32'h13579BDF, 1'b0, 32'h13579BDF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
